// File: rtl/aes_inv_round_core.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Optional block counter port blk_cnt enabled by AES_INV_STAT_EN.

module aes_inv_sbox_128 (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  localparam logic [2047:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] lut(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return INV_SBOX_T[idx -: 8];
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[127-8*i -: 8] = lut(data_i[127-8*i -: 8]);
  end

endmodule

module aes_inv_round_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_INV_STAT_EN
  output logic [15:0]  blk_cnt,
`endif
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    LAST,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients 09/0b/0d/0e built from x2/x4/x8 taps.
  function automatic logic [31:0] imc_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] e9 [4];
    logic [7:0] eb [4];
    logic [7:0] ed [4];
    logic [7:0] ee [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      e9[i] = x8[i] ^ a[i];
      eb[i] = x8[i] ^ x2[i] ^ a[i];
      ed[i] = x8[i] ^ x4[i] ^ a[i];
      ee[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {
      ee[0] ^ eb[1] ^ ed[2] ^ e9[3],
      e9[0] ^ ee[1] ^ eb[2] ^ ed[3],
      ed[0] ^ e9[1] ^ ee[2] ^ eb[3],
      eb[0] ^ ed[1] ^ e9[2] ^ ee[3]
    };
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = imc_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign isr = inv_shift_rows(blk_q);

  aes_inv_sbox_128 u_sbox (
    .data_i (isr),
    .data_o (isb)
  );

  assign ark = isb ^ round_key;
  assign imc = inv_mix(ark);

  always_comb begin
    key_idx = 4'd10;
    unique case (state_q)
      IDLE:    key_idx = 4'd10;
      ROUND:   key_idx = cnt_q;
      LAST:    key_idx = 4'd0;
      DONE:    key_idx = 4'd10;
      default: key_idx = 4'd10;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          blk_d      = in_data ^ round_key;
          cnt_d      = 4'd9;
          in_ready_d = 1'b0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        blk_d = imc;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = LAST;
        end
      end
      LAST: begin
        blk_d       = ark;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = blk_q;

`ifdef AES_INV_STAT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_valid_q && out_ready) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_inv_round_core.sv
// Scoreboard bench for aes_inv_round_core.
// Reference model derives its S-boxes from GF(2^8) arithmetic.

module tb_aes_inv_round_core;

  localparam logic [127:0] C1KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ZCT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
`ifdef AES_INV_STAT_EN
  logic [15:0]  blk_cnt;
  logic [15:0]  cnt0;
`endif

  logic [127:0] ks [11];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] exp_q [$];
  int           n_chk = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  assign round_key = (key_idx <= 4'd10) ? ks[key_idx] : '0;

  aes_inv_round_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AES_INV_STAT_EN
    .blk_cnt   (blk_cnt),
`endif
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic gen_sbox();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
            ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] model(logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = ct ^ ks[10];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          t[rr+4*c] = isb[s[rr+4*((c-rr+4)%4)]];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      v = v ^ ks[r];
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gmul(s[4*c], 8'h0e) ^ gmul(s[4*c+1], 8'h0b)
                   ^ gmul(s[4*c+2], 8'h0d) ^ gmul(s[4*c+3], 8'h09);
          t[4*c+1] = gmul(s[4*c], 8'h09) ^ gmul(s[4*c+1], 8'h0e)
                   ^ gmul(s[4*c+2], 8'h0b) ^ gmul(s[4*c+3], 8'h0d);
          t[4*c+2] = gmul(s[4*c], 8'h0d) ^ gmul(s[4*c+1], 8'h09)
                   ^ gmul(s[4*c+2], 8'h0e) ^ gmul(s[4*c+3], 8'h0b);
          t[4*c+3] = gmul(s[4*c], 8'h0b) ^ gmul(s[4*c+1], 8'h0d)
                   ^ gmul(s[4*c+2], 8'h09) ^ gmul(s[4*c+3], 8'h0e);
        end
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 128'(1), 128'(0));
        else chk("sb_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_rdy", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rdy_drop", 128'(in_ready), 128'(0));
  endtask

  task automatic wait_out(input string tag, input int n0);
    int n;
    n = n0;
    while (!out_valid && n < 40) begin
      if (n < 10)
        chk($sformatf("%s_kidx%0d", tag, n), 128'(key_idx), 128'(9 - n));
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(10));
  endtask

  initial begin
    logic [127:0] held;
    int n;
    gen_sbox();
    expand(C1KEY);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 128'(in_ready), 128'(0));
    chk("rst_vld", 128'(out_valid), 128'(0));
    chk("rst_data", out_data, 128'(0));
    chk("rst_kidx", 128'(key_idx), 128'(10));
    rst = 1'b0;
    chk("rdy_pre", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    chk("rdy_rise", 128'(in_ready), 128'(1));

    send(C1CT);
    wait_out("c1", 0);
    chk("c1_pt", out_data, C1PT);
    @(posedge clk); #1;
    chk("c1_vld_off", 128'(out_valid), 128'(0));
    chk("c1_rdy_on", 128'(in_ready), 128'(1));

    expand('0);
    send(ZCT);
    wait_out("zk", 0);
    chk("zk_pt", out_data, 128'(0));
    @(posedge clk); #1;

    expand(C1KEY);
    out_ready = 1'b0;
    send(C1CT);
    wait_out("bp", 0);
    held = out_data;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", 128'(out_valid), 128'(1));
      chk("bp_hold", out_data, held);
      chk("bp_rdy", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_vld_off", 128'(out_valid), 128'(0));
    chk("bp_rdy_on", 128'(in_ready), 128'(1));

    send(C1CT);
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = ZCT;
    wait_out("busy", 3);
    chk("busy_pt", out_data, C1PT);
    chk("busy_rdy", 128'(in_ready), 128'(0));
    in_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    chk("blk2_rdy", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("blk2_acc", 128'(in_ready), 128'(0));
    wait_out("blk2", 0);
    @(posedge clk); #1;

    send(C1CT);
    n = 0;
    while (key_idx != 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_kidx5", 128'(key_idx), 128'(5));
    #2 rst = 1'b1;
    #1;
    chk("mid_vld", 128'(out_valid), 128'(0));
    chk("mid_rdy", 128'(in_ready), 128'(0));
    chk("mid_kidx", 128'(key_idx), 128'(10));
    chk("mid_data", out_data, 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rdy_on", 128'(in_ready), 128'(1));
    send(C1CT);
    wait_out("post", 0);
    chk("post_pt", out_data, C1PT);
    @(posedge clk); #1;

    expand({$urandom, $urandom, $urandom, $urandom});
`ifdef AES_INV_STAT_EN
    cnt0 = blk_cnt;
`endif
    for (int k = 0; k < 3; k++) begin
      send({$urandom, $urandom, $urandom, $urandom});
      wait_out($sformatf("rnd%0d", k), 0);
    end
    @(posedge clk); #1;
`ifdef AES_INV_STAT_EN
    chk("stat_cnt", 128'(blk_cnt), 128'(16'(cnt0 + 16'd3)));
`endif
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/aes_inv_round_core.md
# aes_inv_round_core

Iterative AES-128 decryption core: one inverse round per clock, built around the 128-bit inverse S-box layer (`aes_inv_sbox_128`). The core consumes that layer's output each cycle and closes the round loop with AddRoundKey and InvMixColumns. It sits between the ciphertext input FIFO and the plaintext output path. Round keys come from an external key store addressed by the core.

## Interface
Parameters: none (AES-128 only, Nr = 10).

- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  ciphertext block available
- `in_ready`  out  1  core idle and able to accept a block
- `in_data`  in  128  ciphertext, FIPS-197 byte order ([127:120] = byte 0, column-major)
- `key_idx`  out  4  round-key index requested (10 down to 0)
- `round_key`  in  128  round key for `key_idx`, combinational, valid in the same cycle
- `out_valid`  out  1  plaintext block valid
- `out_ready`  in  1  downstream accepts plaintext
- `out_data`  out  128  plaintext, same byte order as `in_data`

## Operation
FSM states: IDLE, ROUND, LAST, DONE.

- **IDLE**
  - `in_ready` = 1, `key_idx` = 10.
  - On `in_valid && in_ready`: state reg <= `in_data ^ round_key`, round counter <= 9, go to ROUND.
- **ROUND** (counter r = 9..1)
  - `key_idx` = r.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
  - r decrements by 1. When r = 1 is processed, go to LAST.
- **LAST**
  - `key_idx` = 0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ round_key. InvMixColumns is not applied.
  - `out_valid` <= 1, go to DONE.
- **DONE**
  - `out_data` = state reg, held stable.
  - On `out_valid && out_ready`: `out_valid` <= 0, go to IDLE.
- InvSubBytes is exactly one `aes_inv_sbox_128` instance, shared by all rounds.
- InvMixColumns uses GF(2^8) with polynomial 0x11B and coefficients {0e, 0b, 0d, 09}. It is implemented with xtime chains; no multipliers.
- `in_valid` outside IDLE is ignored; `in_data` is not sampled.
- `key_idx` is a pure function of FSM state and counter. `round_key` is sampled in the same cycle it is requested.

## Timing
- Reset values (asserted asynchronously):
  - FSM = IDLE, counter = 0
  - `in_ready` = 0 (register; rises on the first clock edge after `rst` deasserts)
  - `out_valid` = 0, `out_data` = 0, `key_idx` = 10
- Latency: acceptance at edge E0 → `out_valid` = 1 after edge E10 (9 ROUND edges + 1 LAST edge).
- `in_ready` drops the cycle after acceptance. It returns high the cycle after the output handshake.
- Minimum block period: 12 cycles with `out_ready` held high.
- Back-pressure: while `out_ready` = 0, `out_valid` and `out_data` hold indefinitely.
- Reset mid-block: in-flight data is discarded and no output is produced. After release the core behaves as from power-up.
- Counter never wraps: the ROUND exit is at r = 1, so r = 0 is unreachable in ROUND.

## Configuration
- `AES_INV_STAT_EN` defined:
  - Adds output `blk_cnt` [15:0], reset 0.
  - Increments on each `out_valid && out_ready`.
  - Wraps 0xFFFF → 0x0000.
- `AES_INV_STAT_EN` undefined:
  - Port and counter are absent.
  - Datapath and timing are identical.

## Test plan
- **FIPS-197 C.1 known answer.** Key 000102…0e0f (bench key-schedule model), `in_data` 69c4e0d86a7b0430d8cdb78070b4c55a → `out_data` 00112233445566778899aabbccddeeff, `out_valid` rising 10 edges after acceptance.
- **All-zero key.** Key 0, ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e → plaintext 0. `key_idx` sequence after acceptance is 9,8,…,1,0.
- **Back-pressure.** Hold `out_ready` = 0 for 7 cycles after `out_valid` rises → `out_data` stable, `in_ready` = 0 throughout. Handshake on cycle 8 → `in_ready` = 1 the next cycle.
- **Busy input ignored.** Pulse `in_valid` with a different block during ROUND → first result unchanged; second block accepted only when `in_ready` = 1.
- **Reset mid-block.** Assert `rst` asynchronously while `key_idx` = 5 → `out_valid` = 0 immediately, no spurious output. The next block (C.1 vector) decrypts correctly.
- **Stats (`AES_INV_STAT_EN`).** 3 back-to-back blocks → `blk_cnt` = 3. Preload-by-run to 0xFFFF, then one more handshake → 0x0000.
